// File: rtl/demux_reg_pair.sv
// Receiving-side select register pair: routes accepted bytes into slot A (s=1)
// or slot B (s=0), tracks occupancy with a 4-state FSM and counts refused writes.
module demux_reg_pair #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             s,
  input  logic [W-1:0]     d_in,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             rd_a,
  input  logic             rd_b,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic             a_full,
  output logic             b_full,
  output logic             L,
  output logic [CNT_W-1:0] drops
);

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    HAVE_A = 2'b01,
    HAVE_B = 2'b10,
    BOTH   = 2'b11
  } state_t;

  state_t state, state_next;

  logic wr, wr_a, wr_b;
  logic rd_a_eff, rd_b_eff;
  logic refused;
  logic a_next, b_next;

  assign a_full = (state == HAVE_A) || (state == BOTH);
  assign b_full = (state == HAVE_B) || (state == BOTH);
  assign L      = (state == BOTH);

  // A full slot can still take a write when it is being drained in the same cycle.
  assign d_ready  = enable & (s ? (~a_full | rd_a) : (~b_full | rd_b));
  assign wr       = enable & d_valid & d_ready;
  assign wr_a     = wr & s;
  assign wr_b     = wr & ~s;
  assign rd_a_eff = enable & rd_a & a_full;
  assign rd_b_eff = enable & rd_b & b_full;
  assign refused  = enable & d_valid & ~d_ready;

  always_comb begin
    state_next = state;
    a_next     = (a_full & ~rd_a_eff) | wr_a;
    b_next     = (b_full & ~rd_b_eff) | wr_b;
    case ({b_next, a_next})
      2'b00:   state_next = EMPTY;
      2'b01:   state_next = HAVE_A;
      2'b10:   state_next = HAVE_B;
      default: state_next = BOTH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Reads only clear occupancy; the held value stays visible on a_out/b_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      if (wr_a) a_out <= d_in;
      if (wr_b) b_out <= d_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drops <= '0;
    end else if (refused && (drops != {CNT_W{1'b1}})) begin
      drops <= drops + CNT_W'(1);
    end
  end

endmodule
